// File: rtl/packed_cmd_arbiter.sv
// Round-robin arbiter sharing one packed {we, addr[22:0], data[7:0]} command channel
// between several clients, with read-response routing and a read watchdog.
module packed_cmd_arbiter #(
  parameter int          num_clients_p  = 2,
  parameter int          timeout_p      = 1024,
  parameter logic [31:0] timeout_data_p = 32'hDEAD_BEEF,
  localparam int         id_w           = (num_clients_p > 1) ? $clog2(num_clients_p) : 1,
  localparam int         timer_w        = (timeout_p > 1) ? $clog2(timeout_p) : 1
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [num_clients_p*32-1:0]  client_data_i,
  input  logic [num_clients_p-1:0]     client_v_i,
  output logic [num_clients_p-1:0]     client_ready_o,
  output logic [31:0]                  client_data_o,
  output logic [num_clients_p-1:0]     client_v_o,
  input  logic [num_clients_p-1:0]     client_ready_i,
  output logic [31:0]                  data_o,
  output logic                         v_o,
  input  logic                         ready_i,
  input  logic [31:0]                  data_i,
  input  logic                         v_i,
  output logic                         ready_o,
  output logic [id_w-1:0]              grant_id_o,
  output logic                         busy_o,
  output logic                         timeout_o,
  output logic                         stale_o
);

  typedef enum logic [1:0] {e_idle, e_send, e_read_wait, e_read_resp} state_e;

  localparam logic [timer_w-1:0] timer_max = timer_w'(timeout_p - 1);

  state_e              state_r, state_n;
  logic [id_w-1:0]     ptr_r, ptr_n;
  logic [timer_w-1:0]  timer_r;
  logic [31:0]         cmd_r, resp_r;

  logic                found;
  logic [id_w-1:0]     winner;
  logic [31:0]         sel_cmd;
  logic                grant;
  logic                timer_done;
  int                  idx;

  // Round-robin search starting at the pointer, first valid client wins.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    sel_cmd = '0;
    idx     = 0;
    for (int k = 0; k < num_clients_p; k++) begin
      idx = int'(ptr_r) + k;
      if (idx >= num_clients_p) idx = idx - num_clients_p;
      if (!found && client_v_i[idx]) begin
        found   = 1'b1;
        winner  = id_w'(idx);
        sel_cmd = client_data_i[idx*32 +: 32];
      end
    end
    ptr_n = (int'(winner) == num_clients_p - 1) ? '0 : winner + 1'b1;
  end

  assign timer_done = (timer_r == timer_max);

  always_comb begin
    state_n        = state_r;
    client_ready_o = '0;
    client_v_o     = '0;
    v_o            = 1'b0;
    ready_o        = 1'b0;
    grant          = 1'b0;
    case (state_r)
      e_idle: begin
        ready_o = 1'b1;
        if (found) begin
          grant                  = 1'b1;
          client_ready_o[winner] = 1'b1;
          state_n                = e_send;
        end
      end
      e_send: begin
        v_o     = 1'b1;
        ready_o = 1'b1;
        if (ready_i) state_n = cmd_r[31] ? e_idle : e_read_wait;
      end
      e_read_wait: begin
        ready_o = 1'b1;
        if (v_i || timer_done) state_n = e_read_resp;
      end
      e_read_resp: begin
        client_v_o[grant_id_o] = 1'b1;
        if (client_ready_i[grant_id_o]) state_n = e_idle;
      end
      default: state_n = e_idle;
    endcase
    // Handshakes that depend only on inputs must stay quiet while reset is held.
    if (!reset_n_i) begin
      client_ready_o = '0;
      ready_o        = 1'b0;
      grant          = 1'b0;
    end
  end

  assign data_o        = (state_r == e_send) ? cmd_r : '0;
  assign client_data_o = (state_r == e_read_resp) ? resp_r : '0;
  assign busy_o        = (state_r != e_idle);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= e_idle;
      ptr_r      <= '0;
      grant_id_o <= '0;
      timer_r    <= '0;
      timeout_o  <= 1'b0;
      stale_o    <= 1'b0;
    end else begin
      state_r <= state_n;
      if (grant) begin
        ptr_r      <= ptr_n;
        grant_id_o <= winner;
      end
      if (state_r == e_send && ready_i)
        timer_r <= '0;
      else if (state_r == e_read_wait && !v_i && !timer_done)
        timer_r <= timer_r + 1'b1;
      if (state_r == e_read_wait && !v_i && timer_done)
        timeout_o <= 1'b1;
      // Responses outside a read wait are unsolicited (e.g. late after a timeout).
      if ((state_r == e_idle || state_r == e_send) && v_i)
        stale_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant) cmd_r <= sel_cmd;
    if (state_r == e_read_wait) begin
      if (v_i)             resp_r <= data_i;
      else if (timer_done) resp_r <= timeout_data_p;
    end
  end

endmodule

// File: tb/tb_packed_cmd_arbiter.sv
// Directed bench for packed_cmd_arbiter: write, read routing, fairness,
// backpressure, read timeout, stale drop and asynchronous reset.
module tb_packed_cmd_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] cmd_data;
  logic [1:0]  cmd_v, cmd_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_v, rsp_ready;
  logic [31:0] ds_data;
  logic        ds_v, ds_ready;
  logic [31:0] us_data;
  logic        us_v, us_ready;
  logic [0:0]  grant_id;
  logic        busy, timeout, stale;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int cnt0   = 0;
  int cnt1   = 0;

  packed_cmd_arbiter #(
    .num_clients_p (2),
    .timeout_p     (16),
    .timeout_data_p(32'hDEAD_BEEF)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .client_data_i (cmd_data),
    .client_v_i    (cmd_v),
    .client_ready_o(cmd_ready),
    .client_data_o (rsp_data),
    .client_v_o    (rsp_v),
    .client_ready_i(rsp_ready),
    .data_o        (ds_data),
    .v_o           (ds_v),
    .ready_i       (ds_ready),
    .data_i        (us_data),
    .v_i           (us_v),
    .ready_o       (us_ready),
    .grant_id_o    (grant_id),
    .busy_o        (busy),
    .timeout_o     (timeout),
    .stale_o       (stale)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    cmd_data  = '0;
    cmd_v     = 2'b01;
    rsp_ready = '0;
    ds_ready  = 1'b0;
    us_data   = '0;
    us_v      = 1'b0;

    // Reset state, with a pending request that must not be acknowledged
    tick(); tick(); settle();
    check("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_v_o", 32'(ds_v), 32'h0);
    check("rst_ready_o", 32'(us_ready), 32'h0);
    check("rst_grant", 32'(grant_id), 32'h0);
    check("rst_flags", {30'h0, timeout, stale}, 32'h0);
    cmd_v   = 2'b00;
    reset_n = 1'b1;
    tick();

    // Single write from client0
    cmd_data[31:0] = 32'h8000_12A5;
    cmd_v          = 2'b01;
    ds_ready       = 1'b1;
    settle();
    check("wr_cmd_ready", 32'(cmd_ready), 32'h1);
    check("wr_idle_ready_o", 32'(us_ready), 32'h1);
    tick();
    cmd_v = 2'b00;
    settle();
    check("wr_v_o", 32'(ds_v), 32'h1);
    check("wr_data_o", ds_data, 32'h8000_12A5);
    check("wr_busy", 32'(busy), 32'h1);
    check("wr_no_rsp", 32'(rsp_v), 32'h0);
    tick(); settle();
    check("wr_done_v_o", 32'(ds_v), 32'h0);
    check("wr_done_busy", 32'(busy), 32'h0);

    // Read from client1, response after 5 wait cycles
    cmd_data[63:32] = 32'h0000_3400;
    cmd_v           = 2'b10;
    settle();
    check("rd_cmd_ready", 32'(cmd_ready), 32'h2);
    tick();
    cmd_v = 2'b00;
    settle();
    check("rd_data_o", ds_data, 32'h0000_3400);
    check("rd_grant", 32'(grant_id), 32'h1);
    tick(); settle();
    check("rd_wait_ready_o", 32'(us_ready), 32'h1);
    check("rd_wait_v_o", 32'(ds_v), 32'h0);
    repeat (4) tick();
    us_v    = 1'b1;
    us_data = 32'h0000_0077;
    tick();
    us_v = 1'b0;
    settle();
    check("rd_rsp_v", 32'(rsp_v), 32'h2);
    check("rd_rsp_data", rsp_data, 32'h0000_0077);
    check("rd_rsp_ready_o", 32'(us_ready), 32'h0);
    tick(); settle();
    check("rd_rsp_hold", 32'(rsp_v), 32'h2);
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
    settle();
    check("rd_done_rsp_v", 32'(rsp_v), 32'h0);
    check("rd_done_busy", 32'(busy), 32'h0);
    check("rd_flags", {30'h0, timeout, stale}, 32'h0);

    // Round-robin fairness with both clients always requesting writes
    cmd_data = {32'h8000_0B0B, 32'h8000_0A0A};
    cmd_v    = 2'b11;
    for (int g = 0; g < 8; g++) begin
      settle();
      check("rr_cmd_ready", 32'(cmd_ready), (g % 2 == 0) ? 32'h1 : 32'h2);
      if (cmd_ready[0]) cnt0++;
      if (cmd_ready[1]) cnt1++;
      tick(); settle();
      check("rr_grant", 32'(grant_id), 32'(g % 2));
      check("rr_data_o", ds_data, (g % 2 == 0) ? 32'h8000_0A0A : 32'h8000_0B0B);
      tick();
    end
    cmd_v = 2'b00;
    check("rr_count0", 32'(cnt0), 32'd4);
    check("rr_count1", 32'(cnt1), 32'd4);

    // Downstream backpressure for 10 cycles
    ds_ready       = 1'b0;
    cmd_data[31:0] = 32'h8000_5A5A;
    cmd_v          = 2'b11;
    settle();
    check("bp_cmd_ready", 32'(cmd_ready), 32'h1);
    tick();
    cmd_v = 2'b10;
    for (int i = 0; i < 10; i++) begin
      settle();
      check("bp_v_o", 32'(ds_v), 32'h1);
      check("bp_data_o", ds_data, 32'h8000_5A5A);
      check("bp_no_grant", 32'(cmd_ready), 32'h0);
      tick();
    end
    ds_ready = 1'b1;
    settle();
    check("bp_release_v_o", 32'(ds_v), 32'h1);
    tick(); settle();
    check("bp_done_busy", 32'(busy), 32'h0);
    check("bp_next_grant", 32'(cmd_ready), 32'h2);
    cmd_v = 2'b00;

    // Read with no response: watchdog after 16 wait cycles
    cmd_data[31:0] = 32'h0000_1100;
    cmd_v          = 2'b01;
    settle();
    check("to_cmd_ready", 32'(cmd_ready), 32'h1);
    tick();
    cmd_v = 2'b00;
    tick();
    for (int i = 0; i < 15; i++) begin
      settle();
      check("to_waiting", {30'h0, rsp_v}, 32'h0);
      tick();
    end
    settle();
    check("to_last_wait_timeout", 32'(timeout), 32'h0);
    check("to_last_wait_busy", 32'(busy), 32'h1);
    tick(); settle();
    check("to_rsp_v", 32'(rsp_v), 32'h1);
    check("to_rsp_data", rsp_data, 32'hDEAD_BEEF);
    check("to_timeout", 32'(timeout), 32'h1);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    settle();
    check("to_done_busy", 32'(busy), 32'h0);
    check("to_no_stale_yet", 32'(stale), 32'h0);
    us_v    = 1'b1;
    us_data = 32'h0000_1234;
    tick();
    us_v = 1'b0;
    settle();
    check("stale_set", 32'(stale), 32'h1);
    check("stale_no_rsp", 32'(rsp_v), 32'h0);
    check("stale_timeout_kept", 32'(timeout), 32'h1);

    // Asynchronous reset in the middle of a read wait
    cmd_data[31:0] = 32'h0000_2200;
    cmd_v          = 2'b01;
    tick();
    cmd_v = 2'b00;
    tick(); tick(); tick();
    #3;
    reset_n = 1'b0;
    #1;
    check("ar_busy", 32'(busy), 32'h0);
    check("ar_ready_o", 32'(us_ready), 32'h0);
    check("ar_flags", {30'h0, timeout, stale}, 32'h0);
    check("ar_outputs", {27'h0, grant_id, rsp_v, ds_v}, 32'h0);
    #2;
    reset_n = 1'b1;
    tick();

    // Fresh read; response arrives in the final wait cycle and beats the watchdog
    cmd_data[31:0] = 32'h0000_3300;
    cmd_v          = 2'b01;
    settle();
    check("ar_new_cmd_ready", 32'(cmd_ready), 32'h1);
    tick();
    cmd_v = 2'b00;
    settle();
    check("ar_new_data_o", ds_data, 32'h0000_3300);
    tick();
    repeat (15) tick();
    us_v    = 1'b1;
    us_data = 32'h0000_0055;
    tick();
    us_v = 1'b0;
    settle();
    check("edge_rsp_v", 32'(rsp_v), 32'h1);
    check("edge_rsp_data", rsp_data, 32'h0000_0055);
    check("edge_no_timeout", 32'(timeout), 32'h0);
    check("edge_no_stale", 32'(stale), 32'h0);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    settle();
    check("edge_done_busy", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
